// File: rtl/axis_offload_framer_pkg.sv
// Shared types and constants for the offload framing stage.
package axis_offload_framer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Pointer arithmetic below relies on a power-of-two depth.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/axis_framer_skid.sv
// Two-entry registered skid buffer carrying {last, data} toward the offload port.
module axis_framer_skid
    import axis_offload_framer_pkg::*;
#(
    parameter int WIDTH = 129
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             full,
    output logic             empty
);

    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
    logic [WIDTH-1:0]      mem_d [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        push     = s_valid && (cnt_q != CNT_FULL);
        pop      = m_ready && (cnt_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + SKID_PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + SKID_PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + SKID_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - SKID_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers; reset flushes every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign m_valid = (cnt_q != '0);
    assign m_data  = mem_q[rd_ptr_q];
    assign full    = (cnt_q == CNT_FULL);
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/axis_offload_framer.sv
// Cuts an unframed sample stream into fixed-length TLAST-terminated frames,
// gated by init_req and optionally sync_ext, feeding the offload slave port.
module axis_offload_framer
    import axis_offload_framer_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int LENGTH_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LENGTH_WIDTH-1:0] cfg_length,
    input  logic                    cfg_oneshot,
    input  logic                    cfg_sync_en,
    input  logic                    init_req,
    input  logic                    sync_ext,
    input  logic                    s_axis_valid,
    output logic                    s_axis_ready,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic                    m_axis_last,
    output logic                    busy,
    output logic [15:0]             frame_count
);

    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    state_e                  state_q, state_d;
    logic                    init_q, init_d;
    logic [LENGTH_WIDTH-1:0] len_q, len_d;
    logic [LENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                    s_ready_q, s_ready_d;
    logic                    busy_q, busy_d;
    logic [15:0]             frame_count_q, frame_count_d;

    logic                    init_rise;
    logic                    push;
    logic                    pop;
    logic                    tag_last;
    logic                    start_frame;
    logic                    skid_full;
    logic                    skid_empty;
    logic [DATA_WIDTH:0]     skid_out;
    logic [SKID_CNT_W-1:0]   occ, occ_next;

    axis_framer_skid #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (push),
        .s_data  ({tag_last, s_axis_data}),
        .m_valid (m_axis_valid),
        .m_ready (m_axis_ready),
        .m_data  (skid_out),
        .full    (skid_full),
        .empty   (skid_empty)
    );

    assign m_axis_last = skid_out[DATA_WIDTH];
    assign m_axis_data = skid_out[DATA_WIDTH-1:0];

    // FSM next state, framing counters and the look-ahead used by the registered ready/busy.
    always_comb begin
        init_d        = init_req;
        init_rise     = init_req && !init_q;
        push          = s_axis_valid && s_ready_q && (state_q == RUN);
        pop           = m_axis_valid && m_axis_ready;
        tag_last      = (beat_cnt_q == len_q);
        state_d       = state_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        start_frame   = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (init_rise) begin
                    if (cfg_sync_en) begin
                        state_d = WAIT_SYNC;
                    end else begin
                        state_d     = RUN;
                        start_frame = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_SYNC: begin
                if (sync_ext) begin
                    state_d     = RUN;
                    start_frame = 1'b1;
                end else if (!init_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_SYNC;
                end
            end
            RUN: begin
                if (push && tag_last) begin
                    if (cfg_oneshot) begin
                        state_d = DONE;
                    end else if (init_req) begin
                        state_d     = RUN;
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (push) begin
                    beat_cnt_d = beat_cnt_q + LENGTH_WIDTH'(1);
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!init_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The length is only sampled here, so mid-frame config changes wait for the next frame.
        if (start_frame) begin
            len_d      = cfg_length;
            beat_cnt_d = '0;
        end else begin
            len_d = len_q;
        end

        if (pop && m_axis_last) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end

        case ({skid_full, skid_empty})
            2'b10:   occ = CNT_FULL;
            2'b01:   occ = '0;
            default: occ = SKID_CNT_W'(1);
        endcase
        case ({push, pop})
            2'b10:   occ_next = occ + SKID_CNT_W'(1);
            2'b01:   occ_next = occ - SKID_CNT_W'(1);
            default: occ_next = occ;
        endcase

        // Ready is computed a cycle early from next occupancy so it never depends on m_axis_ready.
        s_ready_d = (state_d != RUN) || (occ_next != CNT_FULL);
        busy_d    = (state_d != IDLE) || (occ_next != '0);
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            init_q        <= 1'b0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign s_axis_ready = s_ready_q;
    assign busy         = busy_q;
    assign frame_count  = frame_count_q;

endmodule
